// File: rtl/rock_pkg.sv
// Shared types and constants for the rocking controller: FSM state codes,
// default parameter values and the level-saturation helper.
package rock_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_LVL_W      = 3;
    localparam int DEF_PRESC_W    = 8;
    localparam int DEF_HOLD_TICKS = 4;
    localparam int DEF_HR_TIMEOUT = 16;
    localparam int STATE_W        = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_FAULT     = 3'd4
    } rock_state_e;

    function automatic int lvl_max(input int lvl_w);
        return (1 << lvl_w) - 1;
    endfunction

endpackage

// File: rtl/rock_regelaar_tick_gen.sv
// Tick prescaler: pulses o_tick once every i_tick_div+1 clock cycles.
// A new divider value is only picked up when the counter reloads.
module tick_gen
#(
    parameter int PRESC_W = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [PRESC_W-1:0] i_tick_div,
    output logic               o_tick
);

    logic [PRESC_W-1:0] r_cnt;

    // Tick is suppressed while reset is held so the first tick lands on the first free cycle.
    assign o_tick = (r_cnt == '0) && !i_reset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= i_tick_div;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/rock_regelaar.sv
// Rocking controller: per tick maps cry volume onto amplitude/frequency levels
// via a ramp/hold FSM; heart-rate limit and heartbeat watchdog force a sticky fault.
module rock_regelaar
    import rock_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LVL_W      = DEF_LVL_W,
    parameter int PRESC_W    = DEF_PRESC_W,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS,
    parameter int HR_TIMEOUT = DEF_HR_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PRESC_W-1:0] tick_div,
    input  logic [DATA_W-1:0]  huil_vol,
    input  logic               huil_valid,
    input  logic [DATA_W-1:0]  hartslag,
    input  logic               hart_valid,
    input  logic [DATA_W-1:0]  huil_drempel,
    input  logic [DATA_W-1:0]  hart_max,
    output logic [LVL_W-1:0]   amp,
    output logic [LVL_W-1:0]   freq,
    output logic               error,
    output logic [STATE_W-1:0] state
);

    localparam int CNT_W = $clog2(HOLD_TICKS + 1);
    localparam int WD_W  = $clog2(HR_TIMEOUT + 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(lvl_max(LVL_W));

    function automatic logic [LVL_W-1:0] lvl_inc(input logic [LVL_W-1:0] v);
        return (v == LVL_MAX) ? v : v + LVL_W'(1);
    endfunction

    function automatic logic [LVL_W-1:0] lvl_dec(input logic [LVL_W-1:0] v);
        return (v == '0) ? v : v - LVL_W'(1);
    endfunction

    logic               w_tick;
    logic [DATA_W-1:0]  r_vol;
    rock_state_e        r_state;
    rock_state_e        w_state_nxt;
    logic [LVL_W-1:0]   r_amp;
    logic [LVL_W-1:0]   w_amp_nxt;
    logic [LVL_W-1:0]   r_freq;
    logic [LVL_W-1:0]   w_freq_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [WD_W-1:0]    r_wd;
    logic [WD_W-1:0]    w_wd_nxt;
    logic [WD_W-1:0]    w_wd_inc;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_cry;
    logic               w_hfault;
    logic               w_wd_active;
    logic               w_wd_expire;

    tick_gen #(
        .PRESC_W (PRESC_W)
    ) u_tick_gen (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_tick_div (tick_div),
        .o_tick     (w_tick)
    );

    // The stored volume (not the one being strobed now) decides this tick.
    assign w_cry       = (r_vol >= huil_drempel);
    assign w_hfault    = hart_valid && (hartslag > hart_max);
    assign w_wd_active = (r_state == ST_RAMP_UP) || (r_state == ST_HOLD) ||
                         (r_state == ST_RAMP_DOWN);
    assign w_wd_inc    = r_wd + WD_W'(1);
    assign w_wd_expire = w_wd_active && w_tick && !hart_valid &&
                         (w_wd_inc == WD_W'(HR_TIMEOUT));
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_amp_nxt   = r_amp;
        w_freq_nxt  = r_freq;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        if (!w_wd_active || hart_valid) begin
            w_wd_nxt = '0;
        end else if (w_tick) begin
            w_wd_nxt = w_wd_inc;
        end else begin
            w_wd_nxt = r_wd;
        end

        // Fault entry overrides any coinciding tick transition.
        if ((r_state == ST_FAULT) || w_hfault || w_wd_expire) begin
            w_state_nxt = ST_FAULT;
            w_amp_nxt   = '0;
            w_freq_nxt  = '0;
            w_cnt_nxt   = '0;
            w_wd_nxt    = '0;
            w_err_nxt   = 1'b1;
        end else if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    w_amp_nxt  = '0;
                    w_freq_nxt = '0;
                    if (!w_cry) begin
                        w_cnt_nxt = '0;
                    end else if (w_cnt_inc == CNT_W'(HOLD_TICKS)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_RAMP_UP;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_RAMP_UP: begin
                    if (w_cry) begin
                        w_amp_nxt  = lvl_inc(r_amp);
                        w_freq_nxt = lvl_inc(r_freq);
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_cry) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_RAMP_UP;
                    end else if (w_cnt_inc == CNT_W'(HOLD_TICKS)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_RAMP_DOWN;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (w_cry) begin
                        w_state_nxt = ST_RAMP_UP;
                    end else begin
                        w_amp_nxt  = lvl_dec(r_amp);
                        w_freq_nxt = lvl_dec(r_freq);
                        if ((w_amp_nxt == '0) && (w_freq_nxt == '0)) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_amp   <= '0;
            r_freq  <= '0;
            r_cnt   <= '0;
            r_wd    <= '0;
            r_err   <= 1'b0;
            r_vol   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_amp   <= w_amp_nxt;
            r_freq  <= w_freq_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wd    <= w_wd_nxt;
            r_err   <= w_err_nxt;
            if (huil_valid) begin
                r_vol <= huil_vol;
            end
        end
    end

    assign amp   = r_amp;
    assign freq  = r_freq;
    assign error = r_err;
    assign state = r_state;

endmodule
